// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extraction behind a two-entry valid/ready skid buffer
module imm_extend_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int IMM_SRC_WIDTH = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              Instr,
  input  logic [IMM_SRC_WIDTH-1:0] ImmSrc,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     Flush,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     ImmErr,
  output logic [CNT_WIDTH-1:0]     ErrCnt
);
  logic [63:0]           w;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] imm_d;
  logic                  acc;
  logic                  sv;
  logic [DATA_WIDTH-1:0] s_op;
  logic                  s_err;
  logic                  unused_bits;
  assign err_d       = ImmSrc > IMM_SRC_WIDTH'(6);
  assign imm_d       = w[DATA_WIDTH-1:0];
  assign acc         = InValid && InReady && !Flush;
  assign unused_bits = ^{Instr[6:0], w};
  // Decode at 64 bits and truncate, so sign extension is right for either width
  always_comb begin
    w = {{52{Instr[31]}}, Instr[31:20]};
    case (ImmSrc)
      IMM_SRC_WIDTH'(1): w = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_SRC_WIDTH'(2): w = {{52{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_SRC_WIDTH'(3): w = {{32{Instr[31]}}, Instr[31:12], 12'b0};
      IMM_SRC_WIDTH'(4): w = {{44{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      IMM_SRC_WIDTH'(5): w = {58'b0, DATA_WIDTH == 64 && Instr[25], Instr[24:20]};
      IMM_SRC_WIDTH'(6): w = {59'b0, Instr[19:15]};
      default: ;
    endcase
  end
  // Output stage refills from the skid entry first; a new beat lands in the skid only under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      OutValid <= 1'b0;
      ImmOp    <= '0;
      ImmErr   <= 1'b0;
      InReady  <= 1'b1;
      sv       <= 1'b0;
      s_op     <= '0;
      s_err    <= 1'b0;
    end else if (Flush) begin
      OutValid <= 1'b0;
      sv       <= 1'b0;
      InReady  <= 1'b1;
    end else if (!OutValid || OutReady) begin
      OutValid <= sv || acc;
      ImmOp    <= sv ? s_op : acc ? imm_d : ImmOp;
      ImmErr   <= sv ? s_err : acc ? err_d : ImmErr;
      sv       <= 1'b0;
      InReady  <= 1'b1;
    end else if (acc) begin
      s_op    <= imm_d;
      s_err   <= err_d;
      sv      <= 1'b1;
      InReady <= 1'b0;
    end
  end
  // Saturating count of accepted illegal-select beats; flush does not touch it
  always_ff @(posedge clk) begin
    if (!rst_n) ErrCnt <= '0;
    else if (acc && err_d && ErrCnt != '1) ErrCnt <= ErrCnt + 1'b1;
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: checks 32- and 64-bit instances against a queue-based reference model
module tb_imm_extend_pipe;
  logic clk = 1'b0, rst_n = 1'b0, inv = 1'b0, flush = 1'b0, ordy = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0] src = '0;
  logic ir32, ov32, er32, ir64, ov64, er64;
  logic [31:0] op32;
  logic [63:0] op64;
  logic [7:0] ec32, ec64;
  int checks = 0, errors = 0;
  typedef struct {logic [63:0] i32; logic [63:0] i64; logic err;} beat_t;
  beat_t q[$];
  bit mrdy = 1'b1;
  int mcnt = 0;
  always #5 clk = ~clk;
  imm_extend_pipe u32 (.clk(clk), .rst_n(rst_n), .Instr(instr), .ImmSrc(src), .InValid(inv), .InReady(ir32), .Flush(flush), .OutValid(ov32), .OutReady(ordy), .ImmOp(op32), .ImmErr(er32), .ErrCnt(ec32));
  imm_extend_pipe #(.DATA_WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .Instr(instr), .ImmSrc(src), .InValid(inv), .InReady(ir64), .Flush(flush), .OutValid(ov64), .OutReady(ordy), .ImmOp(op64), .ImmErr(er64), .ErrCnt(ec64));
  function automatic logic [63:0] ref_imm(logic [31:0] i, int s_sel, bit w64);
    longint s, u;
    s = longint'($signed(i));
    u = longint'({32'b0, i});
    case (s_sel)
      1: return ((s >>> 25) << 5) | ((u >> 7) & 31);
      2: return ((s >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      3: return s & ~64'hFFF;
      4: return ((s >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      5: return (u >> 20) & (w64 ? 63 : 31);
      6: return (u >> 15) & 31;
      default: return s >>> 20;
    endcase
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic model_update();
    bit push;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      mrdy = 1'b1;
      mcnt = 0;
    end else if (flush) begin
      q.delete();
      mrdy = 1'b1;
    end else begin
      push = inv && mrdy;
      if (q.size() > 0 && ordy) q.delete(0);
      if (push) begin
        b.i32 = {32'b0, ref_imm(instr, int'(src), 1'b0) & 64'hFFFF_FFFF};
        b.i64 = ref_imm(instr, int'(src), 1'b1);
        b.err = src == 3'd7;
        q.push_back(b);
        if (b.err && mcnt < 255) mcnt++;
      end
      mrdy = q.size() < 2;
    end
  endtask
  task automatic compare();
    chk("outvalid32", ov32, q.size() > 0);
    chk("outvalid64", ov64, q.size() > 0);
    chk("inready32", ir32, mrdy);
    chk("inready64", ir64, mrdy);
    chk("errcnt32", ec32, mcnt);
    chk("errcnt64", ec64, mcnt);
    if (q.size() > 0) begin
      chk("immop32", op32, q[0].i32);
      chk("immop64", op64, q[0].i64);
      chk("immerr32", er32, q[0].err);
      chk("immerr64", er64, q[0].err);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask
  task automatic put(bit v, logic [31:0] i, int s, bit r);
    inv = v;
    instr = i;
    src = 3'(s);
    ordy = r;
  endtask
  logic [31:0] vecs [9] = '{32'hFFF00093, 32'h800002B7, 32'h00500093, 32'hFE112E23, 32'h7FFFFFFF, 32'h80000000, 32'h12345678, 32'hA5A5A5A5, 32'h03F00000};
  initial begin
    chk("pin_i", ref_imm(32'hFFF00093, 0, 1'b0), 64'hFFFFFFFFFFFFFFFF);
    chk("pin_u", ref_imm(32'h800002B7, 3, 1'b1), 64'hFFFFFFFF80000000);
    chk("pin_sh64", ref_imm(32'h03F00000, 5, 1'b1), 64'h3F);
    chk("pin_sh32", ref_imm(32'h03F00000, 5, 1'b0), 64'h1F);
    chk("pin_s", ref_imm(32'hFE112E23, 1, 1'b0), 64'hFFFFFFFFFFFFFFFC);
    chk("pin_b", ref_imm(32'h80000080, 2, 1'b0), 64'hFFFFFFFFFFFFF800);
    chk("pin_j", ref_imm(32'h80100000, 4, 1'b0), 64'hFFFFFFFFFFF00800);
    put(1, 32'hFFFFFFFF, 7, 1);
    flush = 1'b1;
    cyc();
    cyc();
    chk("rst_immop32", op32, 0);
    chk("rst_immop64", op64, 0);
    chk("rst_immerr", er32, 0);
    rst_n = 1'b1;
    flush = 1'b0;
    put(1, 32'hFFF00093, 0, 1);
    cyc();
    chk("i_valid", ov32, 1);
    chk("i_imm", op32, 32'hFFFFFFFF);
    chk("i_err", er32, 0);
    put(1, 32'h800002B7, 3, 1);
    cyc();
    chk("u64_imm", op64, 64'hFFFFFFFF80000000);
    put(1, 32'h03F00000, 5, 1);
    cyc();
    chk("sh64_imm", op64, 64'h3F);
    chk("sh32_imm", op32, 32'h1F);
    for (int k = 0; k < 72; k++) begin
      put((k % 5) != 4, vecs[k % 9], k / 9, (k % 3) != 0);
      cyc();
    end
    put(0, 0, 0, 1);
    repeat (3) cyc();
    put(0, 0, 0, 0);
    cyc();
    put(1, 32'h00500093, 0, 0);
    cyc();
    put(1, 32'hFE112E23, 1, 0);
    cyc();
    chk("skid_inready", ir32, 0);
    put(1, 32'h12345678, 3, 0);
    cyc();
    chk("hold_a", op32, 32'd5);
    put(1, 32'h12345678, 3, 1);
    cyc();
    chk("drain_b", op32, 32'hFFFFFFFC);
    cyc();
    chk("drain_c", op32, 32'h12345000);
    put(0, 0, 0, 1);
    cyc();
    put(1, 32'hA5A5A5A5, 2, 0);
    cyc();
    put(1, 32'h7FFFFFFF, 4, 0);
    cyc();
    put(1, 32'h80000000, 0, 0);
    flush = 1'b1;
    cyc();
    chk("flush_ov", ov32, 0);
    chk("flush_ir", ir32, 1);
    flush = 1'b0;
    put(0, 0, 0, 1);
    cyc();
    put(1, 32'h12345678, 6, 0);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    put(0, 0, 0, 0);
    cyc();
    chk("flush1_ov", ov32, 0);
    for (int k = 0; k < 260; k++) begin
      put(1, vecs[k % 9], 7, 1);
      cyc();
    end
    put(0, 0, 0, 1);
    cyc();
    chk("sat32", ec32, 255);
    chk("sat64", ec64, 255);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("sat_flush", ec32, 255);
    put(1, 32'hFFF00093, 7, 0);
    cyc();
    cyc();
    rst_n = 1'b0;
    flush = 1'b1;
    put(1, 32'h00500093, 0, 1);
    cyc();
    chk("mrst_ov", ov32, 0);
    chk("mrst_ir", ir32, 1);
    chk("mrst_cnt", ec64, 0);
    rst_n = 1'b1;
    flush = 1'b0;
    put(0, 0, 0, 1);
    cyc();
    chk("post_rst_ov", ov64, 0);
    put(1, 32'h00500093, 0, 1);
    cyc();
    put(0, 0, 0, 1);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter IMM_SRC_WIDTH, default 3, width of the immediate-type select.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of the illegal-select counter.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port Instr, input, 32, instruction word.
REQ-007 SHALL have port ImmSrc, input, IMM_SRC_WIDTH, immediate type select.
REQ-008 SHALL have port InValid, input, 1, upstream beat valid.
REQ-009 SHALL have port InReady, output, 1, block can accept a beat.
REQ-010 SHALL have port Flush, input, 1, discards all held and incoming beats.
REQ-011 SHALL have port OutValid, output, 1, ImmOp/ImmErr valid.
REQ-012 SHALL have port OutReady, input, 1, downstream accepts the beat.
REQ-013 SHALL have port ImmOp, output, DATA_WIDTH, extended immediate.
REQ-014 SHALL have port ImmErr, output, 1, beat carried an illegal ImmSrc.
REQ-015 SHALL have port ErrCnt, output, CNT_WIDTH, count of accepted illegal-select beats.

Function
REQ-016 SHALL decode ImmSrc, with sign extension from Instr[31] to DATA_WIDTH: 000 I {Instr[31:20]}; 001 S {Instr[31:25],Instr[11:7]}; 010 B {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; 011 U {Instr[31:12],12'b0}; 100 J {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}.
REQ-017 SHALL decode 101 as shift amount, zero-extended: Instr[24:20] when DATA_WIDTH=32, Instr[25:20] when 64.
REQ-018 SHALL decode 110 as CSR zimm, Instr[19:15] zero-extended.
REQ-019 SHALL decode 111 (and any unlisted code) to the I-type value, with ImmErr=1 for that beat; ImmErr=0 for all other codes.
REQ-020 SHALL accept a beat when InValid && InReady at a rising edge, absent Flush.
REQ-021 SHALL present an accepted beat on ImmOp/ImmErr with OutValid=1 at the next edge when the output stage is empty or draining; latency exactly 1 cycle.
REQ-022 SHALL be a 2-entry buffer (output stage + skid entry), and InReady SHALL be a register equal to NOT skid-entry-valid.
REQ-023 SHALL write the accepted beat to the skid entry when the output stage is full and OutReady=0; InReady SHALL fall the following cycle.
REQ-024 SHALL, on OutValid && OutReady with the skid entry full, move the skid entry to the output stage and set InReady=1 at the next edge.
REQ-025 SHALL, on simultaneous accept and drain with the skid entry empty, load the new beat into the output stage; OutValid stays 1.
REQ-026 SHALL deliver beats in acceptance order, never dropping or duplicating one; ImmOp/ImmErr SHALL be stable while OutValid=1 and OutReady=0.
REQ-027 SHALL, on Flush=1, invalidate both entries at that edge, discard any same-cycle input beat, and give OutValid=0, InReady=1 the next cycle; ErrCnt unaffected.
REQ-028 SHALL increment ErrCnt once per accepted beat with ImmErr=1, saturating at 2^CNT_WIDTH-1 with no wrap; flushed beats still counted.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set OutValid=0, InReady=1, ImmOp=0, ImmErr=0, ErrCnt=0, skid entry invalid.
REQ-030 SHALL ignore InValid, OutReady and Flush during reset cycles; mid-operation reset discards held beats, with no output beat on the first post-reset cycle.

Verification
REQ-031 SHALL cover: DATA_WIDTH=32, Instr=0xFFF00093, ImmSrc=000, OutReady=1 -> next cycle OutValid=1, ImmOp=0xFFFFFFFF, ImmErr=0.
REQ-032 SHALL cover: DATA_WIDTH=64, Instr=0x800002B7, ImmSrc=011 -> ImmOp=0xFFFFFFFF80000000; same width, ImmSrc=101, Instr[25:20]=0x3F -> ImmOp=0x3F.
REQ-033 SHALL cover: OutReady=0, beats A (I, 0x00500093), B (S, 0xFE112E23) accepted back to back -> InReady=0 after B, C held upstream; OutReady=1 -> outputs 5, then -4, then C, in order.
REQ-034 SHALL cover: both entries full, Flush=1 with InValid=1 -> next cycle OutValid=0, InReady=1, input beat not delivered.
REQ-035 SHALL cover: 260 accepted beats with ImmSrc=111 -> each ImmErr=1, ErrCnt=255 at end; Flush leaves ErrCnt at 255.
REQ-036 SHALL cover: rst_n=0 for one cycle with both entries full -> OutValid=0, InReady=1, ErrCnt=0 next cycle.
